// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment count display:
// scan state encoding, anode/segment constants and the hex glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_DIG0   = 2'b10;
  localparam logic [1:0] AN_DIG1   = 2'b01;

  // Active-low glyphs, bit 0 = segment a, bit 6 = segment g; index = hex value.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = HEX_GLYPH[hex_i];

endmodule

// File: rtl/seg7_count_display.sv
// Display stage for the divided-clock counter: synchronises div_clk_in,
// captures count_in on its rising edge, counts wrap-arounds and scans two
// active-low digits (digit 0 = count, digit 1 = wraps) with blanking gaps.
//
// Optional feature macro: SEG7_DP_EN -- heartbeat on digit 0's decimal
// point, toggled on every capture. Undefined: dp_n tied high.
//
// state  | meaning
// SHOW0  | digit 0 lit with current count, REFRESH_CYCLES cycles
// BLANK0 | all anodes off, BLANK_CYCLES cycles
// SHOW1  | digit 1 lit with wrap count, REFRESH_CYCLES cycles
// BLANK1 | all anodes off, BLANK_CYCLES cycles (reset state)
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_clk_in,
  input  logic [3:0] count_in,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [1:0] an_n,
  output logic [3:0] count_val,
  output logic [3:0] wrap_cnt,
  output logic       sample_pulse
);

  localparam int PHASE_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX);
  localparam logic [PHASE_W-1:0] SHOW_LAST  = PHASE_W'(REFRESH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] BLANK_LAST = PHASE_W'(BLANK_CYCLES - 1);

  logic               sync1_q, sync2_q, hist_q;
  logic               rise;
  logic [3:0]         count_val_q, count_val_d;
  logic [3:0]         wrap_cnt_q, wrap_cnt_d;
  logic               sample_pulse_q;
  scan_state_e        state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_last;
  logic [3:0]         digit;
  logic [6:0]         glyph;
  logic [6:0]         seg_q;
  logic [1:0]         an_q;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= div_clk_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~hist_q;

  // Next count and wrap values; a smaller new value means the counter wrapped.
  always_comb begin
    count_val_d = count_val_q;
    wrap_cnt_d  = wrap_cnt_q;
    if (rise) begin
      count_val_d = count_in;
      if (count_in < count_val_q) begin
        wrap_cnt_d = wrap_cnt_q + 4'd1;
      end
    end
  end

  // Capture registers and the one-cycle capture strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_val_q    <= 4'd0;
      wrap_cnt_q     <= 4'd0;
      sample_pulse_q <= 1'b0;
    end else begin
      count_val_q    <= count_val_d;
      wrap_cnt_q     <= wrap_cnt_d;
      sample_pulse_q <= rise;
    end
  end

  // Select the dwell length of the current state and the digit to decode.
  always_comb begin
    phase_last = BLANK_LAST;
    digit      = count_val_q;
    if (state_q == SHOW0 || state_q == SHOW1) begin
      phase_last = SHOW_LAST;
    end
    if (state_q == SHOW1) begin
      digit = wrap_cnt_q;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i   (digit),
    .seg_n_o (glyph)
  );

  // Scan FSM with phase counter and registered anode/segment outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK1;
      phase_q <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      if (phase_q == phase_last) begin
        phase_q <= '0;
        unique case (state_q)
          SHOW0:   state_q <= BLANK0;
          BLANK0:  state_q <= SHOW1;
          SHOW1:   state_q <= BLANK1;
          default: state_q <= SHOW0;
        endcase
      end else begin
        phase_q <= phase_q + 1'b1;
      end

      unique case (state_q)
        SHOW0: begin
          an_q  <= AN_DIG0;
          seg_q <= glyph;
        end
        SHOW1: begin
          an_q  <= AN_DIG1;
          seg_q <= glyph;
        end
        default: begin
          an_q  <= AN_OFF;
          seg_q <= SEG_BLANK;
        end
      endcase
    end
  end

`ifdef SEG7_DP_EN
  logic hb_q;
  logic dp_q;

  // Heartbeat flag flips per capture and lights digit 0's decimal point.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_q <= 1'b0;
      dp_q <= 1'b1;
    end else begin
      if (sample_pulse_q) begin
        hb_q <= ~hb_q;
      end
      dp_q <= ~((state_q == SHOW0) && hb_q);
    end
  end

  assign dp_n = dp_q;
`else
  assign dp_n = 1'b1;
`endif

  assign seg_n        = seg_q;
  assign an_n         = an_q;
  assign count_val    = count_val_q;
  assign wrap_cnt     = wrap_cnt_q;
  assign sample_pulse = sample_pulse_q;

endmodule

// File: doc/seg7_count_display.md
# seg7_count_display

Downstream display stage for the 4-bit divided-clock counter. It runs entirely in the `clk` domain and samples the counter's slow `div_clk` as a level signal, capturing `counter_out` on each rising edge. It tracks counter wrap-arounds and time-multiplexes two active-low seven-segment digits (digit 0 = current count, digit 1 = wrap count), with blanking gaps between digits to prevent ghosting.

## Interface
Parameters:
- REFRESH_CYCLES, 100000, clk cycles each digit is lit (1 ms at 100 MHz); must be ≥ 2
- BLANK_CYCLES, 1000, clk cycles with all anodes off between digits; must be ≥ 1

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- div_clk_in  in  1  upstream divided clock, treated as asynchronous level
- count_in  in  4  upstream counter value
- seg_n  out  7  segments a..g, active-low; bit 0 = a
- dp_n  out  1  decimal point, active-low
- an_n  out  2  digit anodes, active-low; bit 0 = digit 0
- count_val  out  4  last captured count
- wrap_cnt  out  4  wrap-around count, modulo 16
- sample_pulse  out  1  one-cycle strobe on each capture

## Operation
- `div_clk_in` passes through a 2-flop synchronizer and then a third history flop.
  - A rising edge is detected when sync2=1 and hist=0.
  - On detection, `count_in` is loaded into `count_val` and `sample_pulse` is asserted for one cycle.
  - `count_in` is stable by then, because upstream changes it right after its own `div_clk` edge.
- Wrap detection: on capture, if new value < old `count_val`, `wrap_cnt` increments. 15 wraps to 0.
- Scan FSM has four states: SHOW0 → BLANK0 → SHOW1 → BLANK1 → SHOW0.
  - SHOW states last REFRESH_CYCLES cycles; BLANK states last BLANK_CYCLES cycles.
  - A phase counter, $clog2(max) bits wide, counts from 0 to N-1. At N-1 it clears and the state advances.
- Output decode (registered):
  - SHOW0: an_n=2'b10, seg_n=hex(count_val).
  - SHOW1: an_n=2'b01, seg_n=hex(wrap_cnt).
  - BLANK: an_n=2'b11, seg_n=7'h7F.
- The hex decode covers 0–F fully, with standard glyphs A, b, C, d, E, F.

## Timing
- Reset values:
  - count_val=0, wrap_cnt=0, sample_pulse=0.
  - seg_n=7'h7F, dp_n=1, an_n=2'b11.
  - FSM=BLANK1, phase=0, all synchronizer flops=0.
- Capture latency: if `div_clk_in` rises before clk edge k, `count_val` and `sample_pulse` update at edge k+2.
- Output latency: seg/an/dp outputs lag the FSM state and value registers by one cycle.
- After reset release, an_n first goes to 2'b10 BLANK_CYCLES+1 cycles later.
- A capture during SHOW0 changes seg_n one cycle after `count_val` changes; there is no wait for the next scan.
- A falling edge of `div_clk_in` has no effect. A high level lasting many cycles produces exactly one capture.
- Reset asserted mid-scan or on a capture cycle: reset wins, and all state returns to reset values on that edge.
- Capture with an equal value (no change) is not a wrap.

## Configuration
- `SEG7_DP_EN` defined: dp_n is driven low while SHOW0 is active and a heartbeat flag is 1. The flag toggles on every `sample_pulse` and resets to 0. dp_n is 1 in all other states.
- `SEG7_DP_EN` undefined: dp_n is constant 1 and no heartbeat flop exists.

## Structure
- Shared package `seg7_pkg`:
  - scan state encoding (SHOW0/BLANK0/SHOW1/BLANK1, 2 bits)
  - SEG_BLANK=7'h7F
  - AN_OFF=2'b11
  - the 16-entry hex glyph constants
- Sub-module `hex_to_seg7`: purely combinational 4-bit → 7-bit active-low decoder. It is instantiated once, fed by a mux on the current state.

## Test plan
All scenarios use REFRESH_CYCLES=8 and BLANK_CYCLES=2.
- Reset release with idle inputs → an_n follows 11 for 3 cycles, then 10 (8 cycles), 11 (2), 01 (8), 11 (2), repeating. seg_n=7'h40 ("0") while lit.
- Raise div_clk_in with count_in=4'h9 → sample_pulse high exactly once, 2 edges later. count_val=9, and seg_n=7'h10 on the next SHOW0.
- Captures 14, 15, 0 → wrap_cnt=1, and the SHOW1 digit shows 7'h79 ("1"). Sixteen further wraps → wrap_cnt returns to 1.
- div_clk_in held high 50 cycles while count_in changes → only one capture, of the value present at detection.
- Assert rst during SHOW1 with a capture in the same cycle → next cycle an_n=11, seg_n=7'h7F, count_val=0, wrap_cnt=0.
- With SEG7_DP_EN, two captures → dp_n low in SHOW0 after the first capture and high again after the second. Without the macro, dp_n stays 1 throughout.
